// File: rtl/uart_bus_pkg.sv
// ---------------------------------------------------------------------------
// uart_bus_pkg
// Shared constants and the state encoding for the UART debug bus master.
//   CMD_READ / CMD_WRITE : frame opcodes received from the host
//   RSP_ACK / RSP_ERR    : single-byte response codes sent back to the host
//   state_e              : bus master FSM states (3-bit encoding)
// ---------------------------------------------------------------------------
package uart_bus_pkg;

    localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] RSP_ACK   = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR   = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        BUS  = 3'd3,
        RESP = 3'd4
    } state_e;

endpackage

// File: rtl/uart_bus_resp_shifter.sv
// ---------------------------------------------------------------------------
// uart_bus_resp_shifter
// Four-byte response buffer that hands bytes, most significant first, to a
// UART transmitter.
//   sysclk, reset   : clock, synchronous active-high reset
//   load_word_i     : load word_i, send all 4 bytes
//   word_i          : 32-bit word to send (bits 31:24 first)
//   load_code_i     : load code_i, send just that one byte
//   code_i          : single response code byte
//   tx_ready_i      : transmitter accepts tx_data_o this cycle
//   tx_data_o       : byte presented to the transmitter (registered)
//   tx_valid_o      : tx_data_o valid (registered)
//   last_accept_o   : the final byte is being accepted this cycle
//
// Handshake: a byte transfers on a rising edge where tx_valid_o and
// tx_ready_i are both high; while not accepted, tx_data_o holds its value.
// ---------------------------------------------------------------------------
module uart_bus_resp_shifter (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        load_word_i,
    input  logic [31:0] word_i,
    input  logic        load_code_i,
    input  logic [7:0]  code_i,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        last_accept_o
);

    logic [31:0] buf_q, buf_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        accept;

    assign accept        = valid_q & tx_ready_i;
    assign last_accept_o = accept & (cnt_q == 3'd1);
    assign tx_data_o     = buf_q[31:24];
    assign tx_valid_o    = valid_q;

    always_comb begin
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_word_i) begin
            buf_d   = word_i;
            cnt_d   = 3'd4;
            valid_d = 1'b1;
        end else if (load_code_i) begin
            buf_d   = {code_i, 24'h000000};
            cnt_d   = 3'd1;
            valid_d = 1'b1;
        end else if (accept) begin
            if (cnt_q == 3'd1) begin
                // Last byte gone: drop valid and clear the buffer so
                // tx_data returns to its idle value.
                buf_d   = 32'h0;
                cnt_d   = 3'd0;
                valid_d = 1'b0;
            end else begin
                buf_d = {buf_q[23:0], 8'h00};
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            buf_q   <= 32'h0;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// ---------------------------------------------------------------------------
// uart_bus_master
// Host-side debug bridge: parses 'R'/'W' frames from a UART receive stream,
// performs one peripheral bus access and returns the response bytes to a
// UART transmitter.
//   sysclk, reset      : clock, synchronous active-high reset
//   rx_data, rx_valid  : received byte with one-cycle strobe (no backpressure)
//   tx_data, tx_valid  : response byte, held until accepted
//   tx_ready           : transmitter accepts when tx_valid & tx_ready at edge
//   rd, wr             : one-cycle bus strobes (never both high)
//   addr, wdata        : bus address / write data, held in IDLE
//   rdata              : bus read data, combinational from addr/rd
//   busy               : FSM is not in IDLE
//   err                : one-cycle pulse on timeout abort or dropped byte
//   dbg_state          : current FSM state (uart_bus_pkg::state_e encoding)
//
// Handshake: tx_data moves on a rising edge with tx_valid & tx_ready; tx_data
// is stable while tx_valid is high and not accepted. rx has no backpressure,
// so a byte arriving while busy with BUS/RESP is dropped and flagged on err.
// ---------------------------------------------------------------------------
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int TO_W           = 23
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic        err,
    output logic [2:0]  dbg_state
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e          state_q;
    logic [1:0]      idx_q;
    logic            is_write_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            rd_q;
    logic            wr_q;
    logic            err_q;
    logic [TO_W-1:0] to_cnt_q;

    logic [31:0] addr_shift;
    logic [31:0] wdata_shift;
    logic        load_word;
    logic        load_code;
    logic [7:0]  code;
    logic        last_accept;

    assign addr_shift  = {addr_q[23:0], rx_data};
    assign wdata_shift = {wdata_q[23:0], rx_data};

    // Response loads happen on the same edge the FSM enters RESP, so the
    // byte is already valid in the first RESP cycle.
    always_comb begin
        load_word = 1'b0;
        load_code = 1'b0;
        code      = RSP_ERR;
        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data != CMD_READ && rx_data != CMD_WRITE)
                    load_code = 1'b1;
            end
            ADDR: begin
                if (rx_valid && idx_q == 2'd3 && addr_shift[1:0] != 2'b00)
                    load_code = 1'b1;
            end
            BUS: begin
                if (is_write_q) begin
                    load_code = 1'b1;
                    code      = RSP_ACK;
                end else begin
                    // rdata is valid now because rd is high this cycle.
                    load_word = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            is_write_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        idx_q    <= 2'd0;
                        to_cnt_q <= '0;
                        if (rx_data == CMD_READ) begin
                            is_write_q <= 1'b0;
                            state_q    <= ADDR;
                        end else if (rx_data == CMD_WRITE) begin
                            is_write_q <= 1'b1;
                            state_q    <= ADDR;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                ADDR: begin
                    // A byte arriving in the expiry cycle takes priority.
                    if (rx_valid) begin
                        addr_q   <= addr_shift;
                        to_cnt_q <= '0;
                        idx_q    <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            if (addr_shift[1:0] != 2'b00) begin
                                state_q <= RESP;
                            end else if (is_write_q) begin
                                state_q <= DATA;
                            end else begin
                                state_q <= BUS;
                                rd_q    <= 1'b1;
                            end
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q <= IDLE;
                        idx_q   <= 2'd0;
                        err_q   <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        wdata_q  <= wdata_shift;
                        to_cnt_q <= '0;
                        idx_q    <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= BUS;
                            wr_q    <= 1'b1;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q <= IDLE;
                        idx_q   <= 2'd0;
                        err_q   <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                BUS: begin
                    state_q <= RESP;
                    if (rx_valid)
                        err_q <= 1'b1;
                end
                RESP: begin
                    if (rx_valid)
                        err_q <= 1'b1;
                    if (last_accept)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    uart_bus_resp_shifter u_resp (
        .sysclk        (sysclk),
        .reset         (reset),
        .load_word_i   (load_word),
        .word_i        (rdata),
        .load_code_i   (load_code),
        .code_i        (code),
        .tx_ready_i    (tx_ready),
        .tx_data_o     (tx_data),
        .tx_valid_o    (tx_valid),
        .last_accept_o (last_accept)
    );

    assign rd        = rd_q;
    assign wr        = wr_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// ---------------------------------------------------------------------------
// tb_uart_bus_master
// Directed bench for uart_bus_master: read/write frames, bad command, bad
// alignment, inter-byte timeout, tx backpressure with a dropped byte, and
// reset mid-frame. Responses are collected and compared against exp_q.
// ---------------------------------------------------------------------------
module tb_uart_bus_master;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        err;
    logic [2:0]  dbg_state;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int both_cnt = 0;
    int err_cnt  = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    // ---------------- clock / reset ----------------
    always #5 sysclk = ~sysclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    uart_bus_master #(
        .TIMEOUT_CYCLES (100),
        .TO_W           (8)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Peripheral: one readable register at 0x4000000C, silent otherwise.
    assign rdata = (rd && addr == 32'h4000000C) ? 32'h000000A5 : 32'h0;

    // Monitor on the inactive edge.
    always @(negedge sysclk) begin
        if (tx_valid && tx_ready) got_q.push_back(tx_data);
        if (rd) rd_cnt++;
        if (wr) begin
            wr_cnt++;
            last_waddr = addr;
            last_wdata = wdata;
        end
        if (rd && wr) both_cnt++;
        if (err) err_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            tick();
        end
        chk(tag, {31'h0, busy}, 32'h0);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_resp(input string tag);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk({tag, "_byte"}, {24'h0, got_q.pop_front()}, {24'h0, exp_q.pop_front()});
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic send_read_frame();
        send_byte(8'h52);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h0C);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_rd", {31'h0, rd}, 32'h0);
        chk("rst_wr", {31'h0, wr}, 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_state", {29'h0, dbg_state}, 32'h0);

        // Read 0x4000000C
        send_read_frame();
        chk("rd_strobe", {31'h0, rd}, 32'h1);
        chk("rd_no_wr", {31'h0, wr}, 32'h0);
        chk("rd_addr", addr, 32'h4000000C);
        chk("rd_txv_early", {31'h0, tx_valid}, 32'h0);
        tick();
        chk("rd_txv", {31'h0, tx_valid}, 32'h1);
        chk("rd_strobe_off", {31'h0, rd}, 32'h0);
        chk("rd_first", {24'h0, tx_data}, 32'h0);
        exp_q = '{8'h00, 8'h00, 8'h00, 8'hA5};
        wait_idle("rd_idle");
        check_resp("rd_resp");
        chk("rd_count", rd_cnt, 1);

        // Write 0x0000003C to 0x4000000C
        send_byte(8'h57);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h0C);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h3C);
        chk("wr_strobe", {31'h0, wr}, 32'h1);
        chk("wr_no_rd", {31'h0, rd}, 32'h0);
        chk("wr_addr", addr, 32'h4000000C);
        chk("wr_wdata", wdata, 32'h0000003C);
        exp_q = '{8'h4B};
        wait_idle("wr_idle");
        check_resp("wr_resp");
        chk("wr_count", wr_cnt, 1);
        chk("wr_last_addr", last_waddr, 32'h4000000C);
        chk("wr_last_data", last_wdata, 32'h0000003C);

        // Unknown command
        send_byte(8'h41);
        chk("bad_cmd_busy", {31'h0, busy}, 32'h1);
        chk("bad_cmd_txv", {31'h0, tx_valid}, 32'h1);
        chk("bad_cmd_data", {24'h0, tx_data}, 32'h3F);
        exp_q = '{8'h3F};
        wait_idle("bad_cmd_idle");
        check_resp("bad_cmd_resp");

        // Misaligned read
        send_byte(8'h52);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h0E);
        chk("misalign_no_rd", {31'h0, rd}, 32'h0);
        exp_q = '{8'h3F};
        wait_idle("misalign_idle");
        check_resp("misalign_resp");
        chk("misalign_rd_count", rd_cnt, 1);
        chk("misalign_wr_count", wr_cnt, 1);

        // Inter-byte timeout in ADDR (100 cycles)
        send_byte(8'h57);
        send_byte(8'h40);
        send_byte(8'h00);
        repeat (99) tick();
        chk("to_err_early", {31'h0, err}, 32'h0);
        chk("to_busy_early", {31'h0, busy}, 32'h1);
        tick();
        chk("to_err", {31'h0, err}, 32'h1);
        chk("to_state", {29'h0, dbg_state}, 32'h0);
        chk("to_busy", {31'h0, busy}, 32'h0);
        tick();
        chk("to_err_pulse", {31'h0, err}, 32'h0);
        chk("to_no_wr", wr_cnt, 1);
        chk("to_no_tx", got_q.size(), 0);
        chk("to_err_count", err_cnt, 1);

        // Normal read after timeout
        send_read_frame();
        chk("post_to_rd", {31'h0, rd}, 32'h1);
        exp_q = '{8'h00, 8'h00, 8'h00, 8'hA5};
        wait_idle("post_to_idle");
        check_resp("post_to_resp");

        // Backpressure plus a dropped byte during RESP
        tx_ready = 1'b0;
        send_read_frame();
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", {31'h0, tx_valid}, 32'h1);
            chk("bp_data", {24'h0, tx_data}, 32'h0);
            tick();
        end
        send_byte(8'h55);
        chk("drop_err", {31'h0, err}, 32'h1);
        chk("drop_busy", {31'h0, busy}, 32'h1);
        chk("drop_data", {24'h0, tx_data}, 32'h0);
        tx_ready = 1'b1;
        exp_q = '{8'h00, 8'h00, 8'h00, 8'hA5};
        wait_idle("bp_idle");
        check_resp("bp_resp");
        chk("drop_err_count", err_cnt, 2);

        // Reset in DATA after 2 data bytes
        send_byte(8'h57);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h0C);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("mid_state_data", {29'h0, dbg_state}, 32'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_rd", {31'h0, rd}, 32'h0);
        chk("mid_rst_wr", {31'h0, wr}, 32'h0);
        chk("mid_rst_addr", addr, 32'h0);
        chk("mid_rst_wdata", wdata, 32'h0);
        chk("mid_rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_err", {31'h0, err}, 32'h0);
        chk("mid_rst_state", {29'h0, dbg_state}, 32'h0);
        repeat (5) tick();
        chk("mid_rst_no_wr", wr_cnt, 1);
        chk("mid_rst_no_tx", got_q.size(), 0);
        chk("never_rd_wr", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
